exec_mul_seq: RTL and testbench
===============================

EXEC_MUL_SEQ -- requirements
Module: exec_mul_seq

Interface
REQ-001 SHALL have parameter N, default 64, giving the operand, product and ALU data width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_E  input  1  MUL instruction present in execute stage.
REQ-005 SHALL have port flush_E  input  1  squash the execute-stage instruction.
REQ-006 SHALL have ports opA_E, opB_E  input  N  multiplicand and multiplier (readData1_E/readData2_E).
REQ-007 SHALL have port aluResult_E  input  N  result returned by the shared execute ALU.
REQ-008 SHALL have ports aluA_M, aluB_M  output  N  operands driven to the shared ALU.
REQ-009 SHALL have port aluControl_M  output  4  ALU operation select.
REQ-010 SHALL have port aluSel_M  output  1  high = ALU inputs taken from this block.
REQ-011 SHALL have port busy_E  output  1  stall request to the pipeline registers.
REQ-012 SHALL have port done_E  output  1  one-cycle pulse, product valid.
REQ-013 SHALL have port product_E  output  N  low N bits of opA_E*opB_E.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE with start_E=1 and flush_E=0 SHALL latch mcand=opA_E, mplier=opB_E, acc=0, count=0 and go to RUN; otherwise SHALL stay in IDLE.
REQ-016 busy_E SHALL be combinationally 1 in IDLE when start_E=1 and flush_E=0, 1 in RUN, 0 in DONE and in all other IDLE cycles.
REQ-017 In RUN each cycle: acc <= aluResult_E if mplier[0]=1, else acc unchanged; mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
REQ-018 In RUN aluSel_M=1, aluA_M=acc, aluB_M=mcand, aluControl_M=ADD; outside RUN aluSel_M=0 and aluA_M, aluB_M, aluControl_M=0.
REQ-019 RUN SHALL go to DONE after the cycle in which count=N-1 (N RUN cycles).
REQ-020 Arithmetic SHALL be modulo 2^N; overflow bits discarded; signed and unsigned low halves identical.
REQ-021 DONE SHALL assert done_E=1 for exactly one cycle, load product_E with the final acc, and return to IDLE; start_E in DONE is ignored.
REQ-022 product_E SHALL hold its value until the next DONE.
REQ-023 Latency without early exit: start cycle 0, RUN cycles 1..N, done_E in cycle N+1.
REQ-024 flush_E=1 in RUN SHALL go to IDLE next cycle with no done_E and product_E unchanged; flush_E in DONE SHALL have no effect.
REQ-025 Simultaneous start_E and flush_E in IDLE SHALL not start an operation.

Reset
REQ-026 reset=1 SHALL force IDLE, acc=mcand=mplier=count=0, product_E=0, done_E=0 at the next edge, from any state including mid-RUN.
REQ-027 reset SHALL take priority over start_E and flush_E.

Configuration
REQ-028 With MUL_EARLY_EXIT_EN defined, RUN SHALL go to DONE after any cycle in which the shifted mplier becomes 0, and IDLE with opB_E=0 SHALL go directly to DONE with product 0.
REQ-029 Without MUL_EARLY_EXIT_EN, every operation SHALL take exactly N RUN cycles regardless of operands.

Structure
REQ-030 A shared package SHALL hold the state enum, the ALU ADD code (4'b0010) and the default width.
REQ-031 No sub-module is required; counter and shift registers are inline.

Verification
REQ-032 opA=3, opB=5, no macro -> busy_E 1 in cycles 0..64, done_E in cycle 65, product_E=15.
REQ-033 opA=3, opB=5, MUL_EARLY_EXIT_EN -> 3 RUN cycles, done_E in cycle 4, product_E=15.
REQ-034 opA=0xFFFF_FFFF_FFFF_FFFF, opB=0xFFFF_FFFF_FFFF_FFFF -> product_E=1; opA=2^63, opB=2 -> product_E=0.
REQ-035 flush_E pulsed in cycle 10 of RUN -> IDLE in cycle 11, busy_E=0, no done_E, product_E unchanged.
REQ-036 reset in cycle 20 of RUN -> IDLE, product_E=0, no done_E; new start after reset completes normally.
REQ-037 opB=0 -> product_E=0; done_E in cycle 1 with macro, cycle 65 without.

Source files
------------

// File: rtl/exec_mul_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Optional feature macro: MUL_EARLY_EXIT_EN (see exec_mul_seq.sv).
package exec_mul_seq_pkg;

    // Default operand / product / ALU data width
    localparam int unsigned MUL_WIDTH_DEF = 64;

    // Shared execute-ALU operation code for addition
    localparam logic [3:0] ALU_ADD = 4'b0010;

    // Multiplier sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : exec_mul_seq_pkg

// File: rtl/exec_mul_seq.sv
// Sequential shift-and-add multiplier that borrows the execute-stage ALU
// for its accumulate step. Produces the low N bits of opA_E*opB_E.
// Optional feature macro: MUL_EARLY_EXIT_EN -- finish as soon as the
// remaining multiplier bits are all zero (and skip RUN entirely for opB_E=0).
module exec_mul_seq
    import exec_mul_seq_pkg::*;
#(
    parameter int unsigned N = MUL_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_E,
    input  logic         flush_E,
    input  logic [N-1:0] opA_E,
    input  logic [N-1:0] opB_E,
    input  logic [N-1:0] aluResult_E,
    output logic [N-1:0] aluA_M,
    output logic [N-1:0] aluB_M,
    output logic [3:0]   aluControl_M,
    output logic         aluSel_M,
    output logic         busy_E,
    output logic         done_E,
    output logic [N-1:0] product_E
);

    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_e             state_q,   state_d;
    logic [N-1:0]       mcand_q,   mcand_d;
    logic [N-1:0]       mplier_q,  mplier_d;
    logic [N-1:0]       acc_q,     acc_d;
    logic [N-1:0]       product_q, product_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               last_run;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end

    // Next-state, datapath update and ALU/handshake outputs
    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        product_d    = product_q;
        count_d      = count_q;
        last_run     = 1'b0;
        busy_E       = 1'b0;
        done_E       = 1'b0;
        aluSel_M     = 1'b0;
        aluA_M       = '0;
        aluB_M       = '0;
        aluControl_M = 4'b0000;

        case (state_q)
            IDLE: begin
                // A squashed instruction never starts an operation
                if (start_E && !flush_E) begin
                    busy_E   = 1'b1;
                    mcand_d  = opA_E;
                    mplier_d = opB_E;
                    acc_d    = '0;
                    count_d  = '0;
`ifdef MUL_EARLY_EXIT_EN
                    if (opB_E == '0) begin
                        state_d   = DONE;
                        product_d = '0;
                    end else begin
                        state_d   = RUN;
                    end
`else
                    state_d  = RUN;
`endif
                end
            end

            RUN: begin
                busy_E       = 1'b1;
                aluSel_M     = 1'b1;
                aluA_M       = acc_q;
                aluB_M       = mcand_q;
                aluControl_M = ALU_ADD;
                if (flush_E) begin
                    // Squash: abandon the operation, keep the old product
                    state_d = IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = aluResult_E;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CNT_W'(1);
                    last_run = (count_q == CNT_W'(N - 1));
`ifdef MUL_EARLY_EXIT_EN
                    if (mplier_d == '0) begin
                        last_run = 1'b1;
                    end
`endif
                    if (last_run) begin
                        state_d   = DONE;
                        product_d = acc_d;
                    end
                end
            end

            DONE: begin
                // Product already loaded on entry; start/flush ignored here
                done_E  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product_E = product_q;

    // done_E is a single-cycle pulse
    assert property (@(posedge clk) disable iff (reset) done_E |=> !done_E);

    // The ALU is never claimed in the completion cycle
    assert property (@(posedge clk) disable iff (reset) !(aluSel_M && done_E));

endmodule : exec_mul_seq

// File: tb/tb_exec_mul_seq.sv
// Self-checking bench for exec_mul_seq: the bench plays the shared ALU and
// checks products and handshake timing against a plain-arithmetic model.
module tb_exec_mul_seq;

    localparam int unsigned N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_E;
    logic         flush_E;
    logic [N-1:0] opA_E;
    logic [N-1:0] opB_E;
    logic [N-1:0] aluResult_E;
    logic [N-1:0] aluA_M;
    logic [N-1:0] aluB_M;
    logic [3:0]   aluControl_M;
    logic         aluSel_M;
    logic         busy_E;
    logic         done_E;
    logic [N-1:0] product_E;

    int n_vec = 0;
    int n_err = 0;
    logic [N-1:0] last_prod;

    exec_mul_seq #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_E      (start_E),
        .flush_E      (flush_E),
        .opA_E        (opA_E),
        .opB_E        (opB_E),
        .aluResult_E  (aluResult_E),
        .aluA_M       (aluA_M),
        .aluB_M       (aluB_M),
        .aluControl_M (aluControl_M),
        .aluSel_M     (aluSel_M),
        .busy_E       (busy_E),
        .done_E       (done_E),
        .product_E    (product_E)
    );

    always #5 clk = ~clk;

    // Shared execute ALU: add on code 0010, subtract otherwise
    assign aluResult_E = (aluControl_M == 4'b0010) ? (aluA_M + aluB_M) : (aluA_M - aluB_M);

    // Number of RUN cycles an operation should take
    function automatic int exp_runs(input logic [N-1:0] b);
        int r;
        r = N;
`ifdef MUL_EARLY_EXIT_EN
        r = 0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) r = i + 1;
        end
`endif
        return r;
    endfunction

    function automatic logic [N-1:0] rnd_word();
        logic [N-1:0] w;
        w = {$urandom, $urandom};
        return w;
    endfunction

    // Run one operation from IDLE and record what the DUT did
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         output int done_cyc, output int busy_end, output int sel_cnt,
                         output int done_cnt, output int bus_bad, output logic [N-1:0] prod);
        done_cyc = -1; busy_end = -1; sel_cnt = 0; done_cnt = 0; bus_bad = 0; prod = '0;
        opA_E = a; opB_E = b; start_E = 1'b1;
        for (int c = 0; c < int'(N) + 4; c++) begin
            @(negedge clk);
            if (busy_E !== 1'b1 && busy_end < 0) busy_end = c;
            if (aluSel_M === 1'b1) sel_cnt++;
            else if (aluA_M !== '0 || aluB_M !== '0 || aluControl_M !== 4'b0000) bus_bad++;
            if (done_E === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    prod = product_E;
                end
            end
            @(posedge clk); #1;
            start_E = 1'b0;
            if (done_cyc >= 0 && c >= done_cyc + 1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_E = 1'b1; flush_E = 1'b0; opA_E = 64'd7; opB_E = 64'd9;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (product_E !== '0) begin n_err++; $display("FAIL reset_product got=%h want=0", product_E); end
        n_vec++;
        if (done_E !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done_E); end
        n_vec++;
        if (aluSel_M !== 1'b0) begin n_err++; $display("FAIL reset_alusel got=%b want=0", aluSel_M); end
        @(posedge clk); #1;
        reset = 1'b0; start_E = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_E !== 1'b0 || aluSel_M !== 1'b0) begin
            n_err++; $display("FAIL reset_priority busy=%b sel=%b want=0,0", busy_E, aluSel_M);
        end
        last_prod = '0;
        @(posedge clk); #1;
    endtask

    // Check one complete operation against the model
    task automatic check_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        int dc, be, sc, dn, bb, runs;
        logic [N-1:0] p, exp_p;
        exp_p = a * b;
        runs  = exp_runs(b);
        do_op(a, b, dc, be, sc, dn, bb, p);
        n_vec++;
        if (p !== exp_p) begin n_err++; $display("FAIL %s_product a=%h b=%h got=%h want=%h", tag, a, b, p, exp_p); end
        n_vec++;
        if (dc !== runs + 1) begin n_err++; $display("FAIL %s_done_cycle got=%0d want=%0d", tag, dc, runs + 1); end
        n_vec++;
        if (be !== runs + 1) begin n_err++; $display("FAIL %s_busy_end got=%0d want=%0d", tag, be, runs + 1); end
        n_vec++;
        if (sc !== runs) begin n_err++; $display("FAIL %s_alusel_cycles got=%0d want=%0d", tag, sc, runs); end
        n_vec++;
        if (dn !== 1 || bb !== 0) begin n_err++; $display("FAIL %s_pulse_bus done_pulses=%0d idle_bus=%0d want=1,0", tag, dn, bb); end
        last_prod = exp_p;
    endtask

    task automatic test_directed();
        logic [N-1:0] opa_tab [5];
        logic [N-1:0] opb_tab [5];
        opa_tab = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h1234_5678_9ABC_DEF0, 64'd0};
        opb_tab = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'h0BAD_F00D_0000_0001};
        for (int i = 0; i < 5; i++) check_op("directed", opa_tab[i], opb_tab[i]);
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = rnd_word();
            b = rnd_word() >> $urandom_range(0, N - 1);
            check_op("random", a, b);
        end
    endtask

    task automatic test_flush();
        int dn;
        logic [N-1:0] b;
        b = rnd_word();
        b[N-1] = 1'b1;
        opA_E = rnd_word(); opB_E = b; start_E = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            start_E = 1'b0;
        end
        flush_E = 1'b1;
        @(posedge clk); #1;
        flush_E = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_E !== 1'b0 || aluSel_M !== 1'b0) begin
            n_err++; $display("FAIL flush_idle busy=%b sel=%b want=0,0", busy_E, aluSel_M);
        end
        n_vec++;
        if (product_E !== last_prod) begin n_err++; $display("FAIL flush_product got=%h want=%h", product_E, last_prod); end
        dn = 0;
        for (int c = 0; c < int'(N) + 4; c++) begin
            if (done_E === 1'b1) dn++;
            @(negedge clk);
        end
        n_vec++;
        if (dn !== 0) begin n_err++; $display("FAIL flush_no_done pulses=%0d want=0", dn); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_flush_idle();
        int dn;
        opA_E = 64'd3; opB_E = 64'd5; start_E = 1'b1; flush_E = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy_E !== 1'b0) begin n_err++; $display("FAIL startflush_busy got=%b want=0", busy_E); end
        @(posedge clk); #1;
        start_E = 1'b0; flush_E = 1'b0;
        dn = 0;
        for (int c = 0; c < int'(N) + 4; c++) begin
            @(negedge clk);
            if (done_E === 1'b1 || aluSel_M === 1'b1) dn++;
        end
        n_vec++;
        if (dn !== 0) begin n_err++; $display("FAIL startflush_no_op activity=%0d want=0", dn); end
        @(posedge clk); #1;
    endtask

    // Start held high across DONE, flush pulsed in DONE: second op starts right after
    task automatic test_back_to_back();
        logic [N-1:0] a1, b1, a2, b2, p1, p2;
        int d1, d2, e1, e2;
        a1 = rnd_word(); b1 = rnd_word() >> $urandom_range(0, N - 1);
        a2 = rnd_word(); b2 = rnd_word() >> $urandom_range(0, N - 1);
        e1 = exp_runs(b1) + 1;
        e2 = e1 + exp_runs(b2) + 2;
        d1 = -1; d2 = -1; p1 = '0; p2 = '0;
        opA_E = a1; opB_E = b1; start_E = 1'b1;
        for (int c = 0; c < 3 * int'(N) + 10 && d2 < 0; c++) begin
            @(negedge clk);
            if (done_E === 1'b1) begin
                if (d1 < 0) begin
                    d1 = c; p1 = product_E;
                    opA_E = a2; opB_E = b2; flush_E = 1'b1;
                end else begin
                    d2 = c; p2 = product_E;
                end
            end
            @(posedge clk); #1;
            flush_E = 1'b0;
        end
        start_E = 1'b0;
        n_vec++;
        if (d1 !== e1 || p1 !== a1 * b1) begin
            n_err++; $display("FAIL b2b_first cycle=%0d prod=%h want cycle=%0d prod=%h", d1, p1, e1, a1 * b1);
        end
        n_vec++;
        if (d2 !== e2 || p2 !== a2 * b2) begin
            n_err++; $display("FAIL b2b_second cycle=%0d prod=%h want cycle=%0d prod=%h", d2, p2, e2, a2 * b2);
        end
        last_prod = a2 * b2;
        @(negedge clk);
        n_vec++;
        if (product_E !== last_prod) begin n_err++; $display("FAIL b2b_hold got=%h want=%h", product_E, last_prod); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int dn;
        logic [N-1:0] b;
        b = rnd_word();
        b[N-1] = 1'b1;
        opA_E = rnd_word(); opB_E = b; start_E = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start_E = 1'b0;
        end
        @(negedge clk);
        n_vec++;
        if (aluSel_M !== 1'b1) begin n_err++; $display("FAIL midrun_running sel=%b want=1", aluSel_M); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_E !== 1'b0 || done_E !== 1'b0 || product_E !== '0) begin
            n_err++; $display("FAIL midrun_reset busy=%b done=%b prod=%h want=0,0,0", busy_E, done_E, product_E);
        end
        dn = 0;
        for (int c = 0; c < int'(N) + 4; c++) begin
            @(negedge clk);
            if (done_E === 1'b1) dn++;
        end
        n_vec++;
        if (dn !== 0) begin n_err++; $display("FAIL midrun_no_done pulses=%0d want=0", dn); end
        @(posedge clk); #1;
        check_op("after_reset", rnd_word(), rnd_word());
    endtask

    initial begin
        reset = 1'b1; start_E = 1'b0; flush_E = 1'b0; opA_E = '0; opB_E = '0;
        last_prod = '0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_start_flush_idle();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_exec_mul_seq
